// File: rtl/pipe_ctrl_hazard_unit.sv
// rtl/pipe_ctrl_hazard_unit.sv - ID-stage decode, load-use/branch hazard control and multiplier stall FSM
// Also keeps saturating stall and taken-branch counters.
module pipe_ctrl_hazard_unit #(
  parameter int INST_W  = 32,
  parameter int RADDR_W = 5,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INST_W-1:0]  inst_i,
  input  logic               beq_i,
  input  logic               ex_memread_i,
  input  logic [RADDR_W-1:0] ex_rd_i,
  output logic [2:0]         alu_op_o,
  output logic               alu_src_o,
  output logic               reg_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               mem_to_reg_o,
  output logic               valid_o,
  output logic               pc_write_o,
  output logic               ifid_write_o,
  output logic               idex_write_o,
  output logic               flush_o,
  output logic               pc_sel_o,
  output logic               mul_busy_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   branch_cnt_o
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam int CW       = (MUL_LAT > 4) ? $clog2(MUL_LAT) : 2;
  localparam int MUL_INIT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  branch_q, branch_d;

  logic [2:0]         dec_op;
  logic               dec_src, dec_rw, dec_mr, dec_mw, dec_m2r, dec_valid;
  logic               uses_rs2, is_mul, is_beq;
  logic [RADDR_W-1:0] rs1, rs2;
  logic               luse, busy, taken, mul_go;
  logic               unused_inst;

  assign rs1         = inst_i[15 +: RADDR_W];
  assign rs2         = inst_i[20 +: RADDR_W];
  assign unused_inst = ^{inst_i[INST_W-1:31], inst_i[29:26], inst_i[11:7]};

  always_comb begin
    dec_op    = 3'b000;
    dec_src   = 1'b0;
    dec_rw    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_m2r   = 1'b0;
    dec_valid = 1'b0;
    uses_rs2  = 1'b0;
    is_mul    = 1'b0;
    is_beq    = 1'b0;
    case (inst_i[6:0])
      OP_R: begin
        uses_rs2 = 1'b1;
        case (inst_i[14:12])
          3'b000: begin
            dec_valid = 1'b1;
            dec_rw    = 1'b1;
            if (inst_i[30]) begin
              dec_op = 3'b100;
            end else if (inst_i[25]) begin
              dec_op = 3'b101;
              is_mul = 1'b1;
            end else begin
              dec_op = 3'b011;
            end
          end
          3'b111: begin dec_valid = 1'b1; dec_rw = 1'b1; dec_op = 3'b001; end
          3'b110: begin dec_valid = 1'b1; dec_rw = 1'b1; dec_op = 3'b010; end
          default: ;
        endcase
      end
      OP_ADDI: begin dec_valid = 1'b1; dec_rw = 1'b1; dec_src = 1'b1; dec_op = 3'b011; end
      OP_LW: begin
        dec_valid = 1'b1; dec_rw = 1'b1; dec_src = 1'b1;
        dec_mr = 1'b1; dec_m2r = 1'b1; dec_op = 3'b000;
      end
      OP_SW: begin
        dec_valid = 1'b1; dec_src = 1'b1; dec_mw = 1'b1;
        uses_rs2 = 1'b1; dec_op = 3'b111;
      end
      OP_BEQ: begin dec_valid = 1'b1; uses_rs2 = 1'b1; is_beq = 1'b1; dec_op = 3'b110; end
      default: ;
    endcase
  end

  assign luse   = ex_memread_i && (ex_rd_i != '0) &&
                  ((ex_rd_i == rs1) || (uses_rs2 && (ex_rd_i == rs2)));
  assign busy   = (state_q == S_MUL_BUSY);
  assign taken  = is_beq && beq_i && !luse && !busy;
  assign mul_go = is_mul && !luse && !busy && (MUL_LAT > 1);

  // Busy holds the whole front end; decode stays visible but ID/EX does not capture it.
  always_comb begin
    alu_op_o     = 3'b000;
    alu_src_o    = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    valid_o      = 1'b0;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    idex_write_o = 1'b0;
    flush_o      = 1'b0;
    pc_sel_o     = 1'b0;
    if (rst_i) begin
      if (busy || !luse) begin
        alu_op_o     = dec_op;
        alu_src_o    = dec_src;
        reg_write_o  = dec_rw;
        mem_read_o   = dec_mr;
        mem_write_o  = dec_mw;
        mem_to_reg_o = dec_m2r;
        valid_o      = dec_valid;
      end
      if (!busy) begin
        pc_write_o   = !luse;
        ifid_write_o = !luse;
        idex_write_o = 1'b1;
        flush_o      = taken;
        pc_sel_o     = taken;
      end
    end
  end

  assign mul_busy_o   = busy;
  assign stall_cnt_o  = stall_q;
  assign branch_cnt_o = branch_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    branch_d = branch_q;
    case (state_q)
      S_IDLE: begin
        if (mul_go) begin
          state_d = S_MUL_BUSY;
          cnt_d   = CW'(MUL_INIT);
        end
      end
      S_MUL_BUSY: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if ((luse || busy) && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (taken && (branch_q != '1))         branch_d = branch_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      stall_q  <= '0;
      branch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      branch_q <= branch_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// tb/tb_pipe_ctrl_hazard_unit.sv - directed vector bench for pipe_ctrl_hazard_unit
// Uses a default instance and a CNT_W=2 instance sharing stimulus for saturation.
module tb_pipe_ctrl_hazard_unit;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ADDI = 32'h00508193;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_ADD6 = 32'h00728333;
  localparam logic [31:0] I_ADI5 = 32'h00128193;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  // {alu_op, src, rw, mr, mw, m2r, valid, pcw, ifidw, idexw, flush, pc_sel}
  localparam logic [13:0] E_ADD   = 14'b011_0_1_0_0_0_1_1_1_1_0_0;
  localparam logic [13:0] E_STALL = 14'b000_0_0_0_0_0_0_0_0_1_0_0;
  localparam logic [13:0] E_NOP   = 14'b000_0_0_0_0_0_0_1_1_1_0_0;
  localparam logic [13:0] E_ADDI  = 14'b011_1_1_0_0_0_1_1_1_1_0_0;
  localparam logic [13:0] E_BEQT  = 14'b110_0_0_0_0_0_1_1_1_1_1_1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] inst;
  logic        beq, mr;
  logic [4:0]  rd;

  logic [2:0]  op1, op2;
  logic        s1, rw1, mr1, mw1, m2r1, v1, pw1, iw1, xw1, fl1, ps1, busy1;
  logic        s2, rw2, mr2, mw2, m2r2, v2, pw2, iw2, xw2, fl2, ps2, busy2;
  logic [15:0] stall1, branch1;
  logic [1:0]  stall2, branch2;
  logic [13:0] out1;

  assign out1 = {op1, s1, rw1, mr1, mw1, m2r1, v1, pw1, iw1, xw1, fl1, ps1};

  always #5 clk = ~clk;

  pipe_ctrl_hazard_unit #(.MUL_LAT(3), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst), .beq_i(beq), .ex_memread_i(mr), .ex_rd_i(rd),
    .alu_op_o(op1), .alu_src_o(s1), .reg_write_o(rw1), .mem_read_o(mr1), .mem_write_o(mw1),
    .mem_to_reg_o(m2r1), .valid_o(v1), .pc_write_o(pw1), .ifid_write_o(iw1), .idex_write_o(xw1),
    .flush_o(fl1), .pc_sel_o(ps1), .mul_busy_o(busy1), .stall_cnt_o(stall1), .branch_cnt_o(branch1)
  );

  pipe_ctrl_hazard_unit #(.MUL_LAT(3), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst), .beq_i(beq), .ex_memread_i(mr), .ex_rd_i(rd),
    .alu_op_o(op2), .alu_src_o(s2), .reg_write_o(rw2), .mem_read_o(mr2), .mem_write_o(mw2),
    .mem_to_reg_o(m2r2), .valid_o(v2), .pc_write_o(pw2), .ifid_write_o(iw2), .idex_write_o(xw2),
    .flush_o(fl2), .pc_sel_o(ps2), .mul_busy_o(busy2), .stall_cnt_o(stall2), .branch_cnt_o(branch2)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        beq;
    logic        mr;
    logic [4:0]  rd;
    logic [13:0] exp;
  } vec_t;

  vec_t vt[19];
  int   checks = 0;
  int   passed = 0;
  int   es = 0;
  int   eb = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic [31:0] i, input logic b, input logic m, input logic [4:0] r);
    @(posedge clk);
    #1;
    inst = i; beq = b; mr = m; rd = r;
    #2;
  endtask

  initial begin
    vt[0]  = '{"add",          I_ADD,  1'b0, 1'b0, 5'd0, E_ADD};
    vt[1]  = '{"sub",          I_SUB,  1'b0, 1'b0, 5'd0, 14'b100_0_1_0_0_0_1_1_1_1_0_0};
    vt[2]  = '{"and",          I_AND,  1'b0, 1'b0, 5'd0, 14'b001_0_1_0_0_0_1_1_1_1_0_0};
    vt[3]  = '{"or",           I_OR,   1'b0, 1'b0, 5'd0, 14'b010_0_1_0_0_0_1_1_1_1_0_0};
    vt[4]  = '{"addi",         I_ADDI, 1'b0, 1'b0, 5'd0, E_ADDI};
    vt[5]  = '{"lw",           I_LW,   1'b0, 1'b0, 5'd0, 14'b000_1_1_1_0_1_1_1_1_1_0_0};
    vt[6]  = '{"sw",           I_SW,   1'b0, 1'b0, 5'd0, 14'b111_1_0_0_1_0_1_1_1_1_0_0};
    vt[7]  = '{"beq_nt",       I_BEQ,  1'b0, 1'b0, 5'd0, 14'b110_0_0_0_0_0_1_1_1_1_0_0};
    vt[8]  = '{"beq_taken",    I_BEQ,  1'b1, 1'b0, 5'd0, E_BEQT};
    vt[9]  = '{"luse_rs1",     I_ADD6, 1'b0, 1'b1, 5'd5, E_STALL};
    vt[10] = '{"luse_rd0",     I_ADD6, 1'b0, 1'b1, 5'd0, E_ADD};
    vt[11] = '{"no_memread",   I_ADD6, 1'b0, 1'b0, 5'd5, E_ADD};
    vt[12] = '{"luse_addi",    I_ADI5, 1'b0, 1'b1, 5'd5, E_STALL};
    vt[13] = '{"addi_no_rs2",  I_ADI5, 1'b0, 1'b1, 5'd1, E_ADDI};
    vt[14] = '{"luse_sw_rs2",  I_SW,   1'b0, 1'b1, 5'd2, E_STALL};
    vt[15] = '{"luse_beq",     I_BEQ,  1'b1, 1'b1, 5'd2, E_STALL};
    vt[16] = '{"luse_r_rs2",   I_ADD6, 1'b0, 1'b1, 5'd7, E_STALL};
    vt[17] = '{"bad_opcode",   I_BAD,  1'b0, 1'b0, 5'd0, E_NOP};
    vt[18] = '{"bad_funct3",   I_SLL,  1'b0, 1'b0, 5'd0, E_NOP};

    rst_i = 1'b0; inst = I_ADD; beq = 1'b1; mr = 1'b0; rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {out1, busy1}, 0);
    chk("rst_counters", {stall1, branch1}, 0);
    @(negedge clk) rst_i = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].inst, vt[i].beq, vt[i].mr, vt[i].rd);
      chk(vt[i].name, out1, vt[i].exp);
      if (!vt[i].exp[4]) es++;
      if (vt[i].exp[1]) eb++;
    end
    drive(I_ADD, 1'b0, 1'b0, 5'd0);
    chk("stall_cnt", stall1, es);
    chk("branch_cnt", branch1, eb);
    chk("stall_cnt_sat2", stall2, (es > 3) ? 3 : es);
    chk("branch_cnt_w2", branch2, eb);

    drive(I_MUL, 1'b0, 1'b0, 5'd0);
    chk("mul_issue", {out1, busy1}, {14'b101_0_1_0_0_0_1_1_1_1_0_0, 1'b0});
    for (int c = 1; c <= 2; c++) begin
      drive(I_BEQ, 1'b1, 1'b0, 5'd0);
      chk($sformatf("mul_busy_c%0d", c), {out1, busy1}, {14'b110_0_0_0_0_0_1_0_0_0_0_0, 1'b1});
    end
    drive(I_ADD, 1'b0, 1'b0, 5'd0);
    chk("mul_done", {out1, busy1}, {E_ADD, 1'b0});
    es += 2;
    chk("mul_stall_cnt", stall1, es);
    chk("mul_branch_cnt", branch1, eb);

    drive(I_MUL, 1'b0, 1'b0, 5'd0);
    drive(I_ADD, 1'b0, 1'b0, 5'd0);
    chk("busy_before_rst", busy1, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_in_busy", {out1, busy1, stall1, branch1}, 0);
    @(negedge clk) rst_i = 1'b1;
    drive(I_ADD, 1'b0, 1'b0, 5'd0);
    chk("post_rst_idle", {out1, busy1}, {E_ADD, 1'b0});
    chk("post_rst_cnt", {stall1, branch1}, 0);

    for (int k = 0; k < 5; k++) begin
      drive(I_BEQ, 1'b1, 1'b0, 5'd0);
      chk($sformatf("taken_%0d", k), out1, E_BEQT);
    end
    drive(I_ADD, 1'b0, 1'b0, 5'd0);
    chk("branch_sat_w2", branch2, 3);
    chk("branch_cnt_5", branch1, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
